// File: rtl/branch_predictor_gen2.sv
// Two-level branch predictor: PHT of saturating counters indexed by {PC, history} or
// PC ^ history, with speculative/architectural global history and mispredict repair.
module branch_predictor_gen2 #(
    parameter int unsigned HIST_W  = 4,
    parameter int unsigned PC_BITS = 2,
    parameter int unsigned PC_LSB  = 4,
    parameter int unsigned CTR_W   = 2,
    parameter int unsigned MODE    = 0,
    localparam int unsigned IDX_W  = (MODE == 0) ? PC_BITS + HIST_W : HIST_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             predict_valid,
    input  logic [15:0]      current_PC,
    input  logic [8:0]       target_offset,
    output logic             prediction,
    output logic [IDX_W-1:0] pred_index,
    output logic [15:0]      target_address,
    input  logic             load_BR,
    input  logic             BR_taken,
    input  logic [IDX_W-1:0] upd_index,
    input  logic             mispredict,
    output logic [15:0]      br_count,
    output logic [15:0]      mispred_count
);

    localparam int unsigned    PHT_N    = 2 ** IDX_W;
    localparam logic [CTR_W-1:0] CTR_INIT = {1'b0, {(CTR_W - 1){1'b1}}};
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [15:0]      CNT_MAX  = 16'hFFFF;

    logic [CTR_W-1:0]  pht [PHT_N];
    logic [HIST_W-1:0] spec_hist;
    logic [HIST_W-1:0] arch_hist;
    logic [HIST_W-1:0] arch_next;
    logic [IDX_W-1:0]  rd_index;
    logic [CTR_W-1:0]  upd_ctr;
    logic [CTR_W-1:0]  ctr_next;

    // Read index: concatenated PC/history or gshare fold
    generate
        if (MODE == 0) begin : g_concat
            assign rd_index = {current_PC[PC_LSB +: PC_BITS], spec_hist};
        end else begin : g_gshare
            assign rd_index = current_PC[PC_LSB +: HIST_W] ^ spec_hist;
        end
    endgenerate

    assign pred_index     = rd_index;
    assign prediction     = pht[rd_index][CTR_W-1];
    assign target_address = current_PC + {{6{target_offset[8]}}, target_offset, 1'b0};
    assign arch_next      = {arch_hist[HIST_W-2:0], BR_taken};

    // Saturating up/down step of the entry being resolved
    always_comb begin
        upd_ctr  = pht[upd_index];
        ctr_next = upd_ctr;
        if (BR_taken) begin
            if (upd_ctr != CTR_MAX) begin
                ctr_next = upd_ctr + CTR_W'(1);
            end
        end else if (upd_ctr != '0) begin
            ctr_next = upd_ctr - CTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < PHT_N; i++) begin
                pht[i] <= CTR_INIT;
            end
        end else if (load_BR) begin
            pht[upd_index] <= ctr_next;
        end
    end

    // Repair from the resolved history wins over a wrong-path predict
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            spec_hist <= '0;
            arch_hist <= '0;
        end else begin
            if (load_BR) begin
                arch_hist <= arch_next;
            end
            if (load_BR && mispredict) begin
                spec_hist <= arch_next;
            end else if (predict_valid) begin
                spec_hist <= {spec_hist[HIST_W-2:0], prediction};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            br_count      <= '0;
            mispred_count <= '0;
        end else if (load_BR) begin
            if (br_count != CNT_MAX) begin
                br_count <= br_count + 16'd1;
            end
            if (mispredict && (mispred_count != CNT_MAX)) begin
                mispred_count <= mispred_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor_gen2.sv
// Directed bench for branch_predictor_gen2: concat (default), gshare and 3-bit-counter builds.
module tb_branch_predictor_gen2;

    logic clk;
    logic reset_n;

    // Concat-mode default instance
    logic        a_pv, a_ld, a_tk, a_mp, a_pred;
    logic [15:0] a_pc, a_tgt, a_brc, a_mpc;
    logic [8:0]  a_off;
    logic [5:0]  a_ui, a_pidx;

    // Gshare instance
    logic        g_pv, g_ld, g_tk, g_mp, g_pred;
    logic [15:0] g_pc, g_tgt, g_brc, g_mpc;
    logic [8:0]  g_off;
    logic [3:0]  g_ui, g_pidx;

    // 3-bit counter instance
    logic        c_pv, c_ld, c_tk, c_mp, c_pred;
    logic [15:0] c_pc, c_tgt, c_brc, c_mpc;
    logic [8:0]  c_off;
    logic [5:0]  c_ui, c_pidx;

    int n_pass  = 0;
    int n_total = 0;

    branch_predictor_gen2 u_cat (
        .clk(clk), .reset_n(reset_n), .predict_valid(a_pv), .current_PC(a_pc),
        .target_offset(a_off), .prediction(a_pred), .pred_index(a_pidx),
        .target_address(a_tgt), .load_BR(a_ld), .BR_taken(a_tk), .upd_index(a_ui),
        .mispredict(a_mp), .br_count(a_brc), .mispred_count(a_mpc)
    );

    branch_predictor_gen2 #(.MODE(1)) u_gsh (
        .clk(clk), .reset_n(reset_n), .predict_valid(g_pv), .current_PC(g_pc),
        .target_offset(g_off), .prediction(g_pred), .pred_index(g_pidx),
        .target_address(g_tgt), .load_BR(g_ld), .BR_taken(g_tk), .upd_index(g_ui),
        .mispredict(g_mp), .br_count(g_brc), .mispred_count(g_mpc)
    );

    branch_predictor_gen2 #(.CTR_W(3)) u_c3 (
        .clk(clk), .reset_n(reset_n), .predict_valid(c_pv), .current_PC(c_pc),
        .target_offset(c_off), .prediction(c_pred), .pred_index(c_pidx),
        .target_address(c_tgt), .load_BR(c_ld), .BR_taken(c_tk), .upd_index(c_ui),
        .mispredict(c_mp), .br_count(c_brc), .mispred_count(c_mpc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance n rising edges, then step off the edge
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        a_pv = 0; a_ld = 0; a_tk = 0; a_mp = 0; a_ui = '0; a_pc = 16'h0030; a_off = 9'h1FE;
        g_pv = 0; g_ld = 0; g_tk = 0; g_mp = 0; g_ui = '0; g_pc = 16'h0050; g_off = 9'h1FE;
        c_pv = 0; c_ld = 0; c_tk = 0; c_mp = 0; c_ui = '0; c_pc = 16'h0030; c_off = 9'h000;
        #12;
        reset_n = 1'b1;
        #1;

        // Reset state and combinational outputs
        chk("rst_pred",    32'(a_pred), 32'h0);
        chk("rst_pidx",    32'(a_pidx), 32'h30);
        chk("rst_tgt",     32'(a_tgt),  32'h002C);
        chk("rst_brc",     32'(a_brc),  32'h0);
        chk("rst_mpc",     32'(a_mpc),  32'h0);
        chk("rst_g_pidx",  32'(g_pidx), 32'h5);
        chk("rst_g_tgt",   32'(g_tgt),  32'h004C);
        chk("rst_g_cnt",   32'({g_brc, g_mpc}), 32'h0);
        chk("rst_c_tgt",   32'(c_tgt),  32'h0030);
        chk("rst_c_cnt",   32'({c_brc, c_mpc}), 32'h0);
        chk("rst_c_pred",  32'(c_pred), 32'h0);
        chk("rst_c3_init", 32'(u_c3.pht[5]), 32'h3);

        // Target arithmetic: positive, negative, wraparound
        a_off = 9'h0FF; #1;
        chk("tgt_pos", 32'(a_tgt), 32'h022E);
        a_off = 9'h100; #1;
        chk("tgt_neg", 32'(a_tgt), 32'hFE30);
        a_pc = 16'hFFFE; a_off = 9'h002; #1;
        chk("tgt_wrap", 32'(a_tgt), 32'h0002);
        a_pc = 16'h0030; a_off = 9'h1FE; #1;

        // Train PHT[0x30]: 01 -> 10 -> 11 -> 11 -> 10
        a_ld = 1; a_tk = 1; a_ui = 6'h30;
        tick(1);
        chk("train1_pred", 32'(a_pred), 32'h1);
        tick(2);
        chk("train3_pred", 32'(a_pred), 32'h1);
        chk("train3_ctr",  32'(u_cat.pht[6'h30]), 32'h3);
        a_tk = 0;
        tick(1);
        chk("train4_ctr",  32'(u_cat.pht[6'h30]), 32'h2);
        chk("train4_pred", 32'(a_pred), 32'h1);
        chk("train4_brc",  32'(a_brc), 32'h4);
        chk("train4_arch", 32'(u_cat.arch_hist), 32'hE);

        // Mispredict repair copies new arch history (1100) into spec
        a_mp = 1;
        tick(1);
        chk("repair_pidx", 32'(a_pidx), 32'h3C);
        chk("repair_pred", 32'(a_pred), 32'h0);
        chk("repair_brc",  32'(a_brc), 32'h5);
        chk("repair_mpc",  32'(a_mpc), 32'h1);

        // mispredict / BR_taken without load_BR change nothing
        a_ld = 0; a_tk = 1;
        tick(1);
        chk("noload_brc",  32'(a_brc), 32'h5);
        chk("noload_mpc",  32'(a_mpc), 32'h1);
        chk("noload_pidx", 32'(a_pidx), 32'h3C);
        a_mp = 0; a_tk = 0;

        // Gshare: train entry F, then steer spec_hist to 1010 through predictions
        g_ld = 1; g_tk = 1; g_ui = 4'hF;
        tick(2);
        g_ld = 0; g_tk = 0;
        g_pc = 16'h00F0; g_pv = 1; #1;
        chk("gs1_pidx", 32'(g_pidx), 32'hF);
        chk("gs1_pred", 32'(g_pred), 32'h1);
        tick(1);
        g_pc = 16'h0000; #1;
        chk("gs2_pidx", 32'(g_pidx), 32'h1);
        chk("gs2_pred", 32'(g_pred), 32'h0);
        tick(1);
        g_pc = 16'h00D0; #1;
        chk("gs3_pidx", 32'(g_pidx), 32'hF);
        chk("gs3_pred", 32'(g_pred), 32'h1);
        tick(1);
        g_pc = 16'h0000; #1;
        chk("gs4_pidx", 32'(g_pidx), 32'h5);
        tick(1);
        g_pv = 0; g_pc = 16'h0050; #1;
        chk("gs_final_pidx", 32'(g_pidx), 32'hF);
        chk("gs_final_pred", 32'(g_pred), 32'h1);

        // 3-bit build: train 0x30/0x31 taken, then flush arch history back to 0000
        c_ld = 1; c_tk = 1; c_ui = 6'h30;
        tick(1);
        c_ui = 6'h31;
        tick(1);
        c_tk = 0; c_ui = 6'h00;
        tick(4);
        c_ld = 0; #1;
        chk("c3_pidx0", 32'(c_pidx), 32'h30);
        chk("c3_pred0", 32'(c_pred), 32'h1);
        c_pv = 1;
        tick(1);
        chk("c3_pidx1", 32'(c_pidx), 32'h31);
        chk("c3_pred1", 32'(c_pred), 32'h1);
        tick(1);
        chk("c3_pidx2", 32'(c_pidx), 32'h33);

        // Repair overrides a simultaneous predict
        c_ld = 1; c_tk = 0; c_mp = 1; c_ui = 6'h31;
        tick(1);
        c_pv = 0; c_ld = 0; c_mp = 0;
        chk("c3_repair_pidx", 32'(c_pidx), 32'h30);
        chk("c3_repair_mpc",  32'(c_mpc), 32'h1);
        chk("c3_repair_brc",  32'(c_brc), 32'h7);

        // Counter saturation at 111 and 000
        c_ld = 1; c_tk = 1; c_ui = 6'h3F;
        tick(8);
        chk("c3_sat_hi", 32'(u_c3.pht[6'h3F]), 32'h7);
        c_tk = 0;
        tick(4);
        chk("c3_mid", 32'(u_c3.pht[6'h3F]), 32'h3);
        tick(5);
        chk("c3_sat_lo", 32'(u_c3.pht[6'h3F]), 32'h0);
        c_ld = 0;
        chk("c3_brc", 32'(c_brc), 32'd24);

        // Performance counter saturation: 65540 mispredicted resolves
        a_ld = 1; a_mp = 1; a_ui = 6'h00;
        tick(65530);
        chk("cnt_brc_edge", 32'(a_brc), 32'hFFFF);
        chk("cnt_mpc_edge", 32'(a_mpc), 32'hFFFB);
        tick(10);
        chk("cnt_brc_sat", 32'(a_brc), 32'hFFFF);
        chk("cnt_mpc_sat", 32'(a_mpc), 32'hFFFF);

        // Asynchronous reset mid-cycle
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_brc",  32'(a_brc), 32'h0);
        chk("arst_mpc",  32'(a_mpc), 32'h0);
        chk("arst_pred", 32'(a_pred), 32'h0);
        chk("arst_pidx", 32'(a_pidx), 32'h30);
        chk("arst_g_pidx", 32'(g_pidx), 32'h5);
        chk("arst_c_brc",  32'(c_brc), 32'h0);
        chk("arst_c3_ctr", 32'(u_c3.pht[6'h3F]), 32'h3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
